// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and lane-slice constants for the systolic datapath
package tpu_pkg;

    // Output-writer sequencing: wait for a tile, sweep the skewed window, flag completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sow_state_t;

    // Per-lane slice widths, common to the weight-load control and the output writer.
    localparam int LANE_DATA_W = 8;
    localparam int LANE_ADDR_W = 8;

    // Sample counter must reach ROWS+WIDTH-2, the last row of the most-delayed lane.
    function automatic int sow_cnt_width(input int rows, input int width);
        return $clog2(rows + width);
    endfunction

endpackage

// File: rtl/sys_out_lane.sv
// rtl/sys_out_lane.sv - one de-skew lane: window compare plus registered write port
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   run             writer is sweeping the sample window
//   cnt             sample counter shared by all lanes
//   base            latched row-0 address of the tile
//   col             this lane's slice of the skewed array output
//   wr_en/wr_addr/wr_data   registered memory write for this lane's bank
module sys_out_lane #(
    parameter int LANE   = 0,
    parameter int ROWS   = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] col,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [CNT_W:0] LANE_OFS = (CNT_W + 1)'(LANE);
    localparam logic [CNT_W:0] NUM_ROWS = (CNT_W + 1)'(ROWS);

    // Row index relative to this lane's skew. One extra bit keeps cnt < LANE
    // as a large value, so a single unsigned compare covers both window edges.
    logic [CNT_W:0] row;
    logic           hit;

    assign row = {1'b0, cnt} - LANE_OFS;
    assign hit = run && (row < NUM_ROWS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (hit) begin
            wr_en   <= 1'b1;
            wr_addr <= base + ADDR_W'(row[CNT_W-1:0]);   // wraps modulo 2^ADDR_W
            wr_data <= col;
        end else begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end
    end

endmodule

// File: rtl/sys_out_writer.sv
// rtl/sys_out_writer.sv - de-skews the systolic result stream into banked memory writes
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           tile start pulse, honoured only when idle
//   base_addr       row-0 address, captured with start
//   col_in          skewed array outputs, lane c at [c*DATA_W +: DATA_W]
//   wr_en           per-lane write enable
//   wr_addr         per-lane address, lane c at [c*ADDR_W +: ADDR_W]
//   wr_data         per-lane data, lane c at [c*DATA_W +: DATA_W]
//   busy            tile in progress (RUN and DONE)
//   done            one-cycle pulse after the final write
module sys_out_writer
    import tpu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ROWS   = 16,
    parameter int DATA_W = LANE_DATA_W,
    parameter int ADDR_W = LANE_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [WIDTH*DATA_W-1:0]  col_in,
    output logic [WIDTH-1:0]         wr_en,
    output logic [WIDTH*ADDR_W-1:0]  wr_addr,
    output logic [WIDTH*DATA_W-1:0]  wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int              CNT_W    = sow_cnt_width(ROWS, WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS + WIDTH - 2);

    sow_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base_q;
    logic              run;

    assign run = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            base_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        base_q <= base_addr;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    // Last sample belongs to the most-delayed lane; its write lands in DONE.
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_lane
        sys_out_lane #(
            .LANE   (c),
            .ROWS   (ROWS),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .run     (run),
            .cnt     (cnt),
            .base    (base_q),
            .col     (col_in[c*DATA_W +: DATA_W]),
            .wr_en   (wr_en[c]),
            .wr_addr (wr_addr[c*ADDR_W +: ADDR_W]),
            .wr_data (wr_data[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_sys_out_writer.sv
// tb/tb_sys_out_writer.sv - self-checking bench for sys_out_writer
module tb_sys_out_writer;

    localparam int WIDTH  = 16;
    localparam int ROWS   = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int NOBS   = 96;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [WIDTH*DATA_W-1:0] col_in = '0;
    logic [WIDTH-1:0]        wr_en;
    logic [WIDTH*ADDR_W-1:0] wr_addr;
    logic [WIDTH*DATA_W-1:0] wr_data;
    logic                    busy;
    logic                    done;

    sys_out_writer #(
        .WIDTH(WIDTH), .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .col_in(col_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Tiles the model expects to run: start edge offset and base address.
    logic [7:0] tile_dat [2][ROWS][WIDTH];
    int         tile_t   [2];
    logic [7:0] tile_base[2];
    int         n_tiles = 0;

    // Observations after edge T+k are stored at index k+1 (the spec's "at T+k+1").
    logic [WIDTH-1:0]        obs_en  [NOBS];
    logic [WIDTH*ADDR_W-1:0] obs_addr[NOBS];
    logic [WIDTH*DATA_W-1:0] obs_data[NOBS];
    logic                    obs_busy[NOBS];
    logic                    obs_done[NOBS];

    function automatic logic [WIDTH-1:0] model_en(input int s);
        logic [WIDTH-1:0] v = '0;
        for (int i = 0; i < n_tiles; i++)
            for (int c = 0; c < WIDTH; c++) begin
                int r = s - tile_t[i] - 2 - c;
                if (r >= 0 && r < ROWS) v[c] = 1'b1;
            end
        return v;
    endfunction

    function automatic logic [WIDTH*ADDR_W-1:0] model_addr(input int s);
        logic [WIDTH*ADDR_W-1:0] v = '0;
        for (int i = 0; i < n_tiles; i++)
            for (int c = 0; c < WIDTH; c++) begin
                int r = s - tile_t[i] - 2 - c;
                if (r >= 0 && r < ROWS) v[c*ADDR_W +: ADDR_W] = tile_base[i] + 8'(r);
            end
        return v;
    endfunction

    function automatic logic [WIDTH*DATA_W-1:0] model_data(input int s);
        logic [WIDTH*DATA_W-1:0] v = '0;
        for (int i = 0; i < n_tiles; i++)
            for (int c = 0; c < WIDTH; c++) begin
                int r = s - tile_t[i] - 2 - c;
                if (r >= 0 && r < ROWS) v[c*DATA_W +: DATA_W] = tile_dat[i][r][c];
            end
        return v;
    endfunction

    function automatic logic model_busy(input int s);
        logic b = 1'b0;
        for (int i = 0; i < n_tiles; i++)
            if (s - tile_t[i] >= 1 && s - tile_t[i] <= ROWS + WIDTH) b = 1'b1;
        return b;
    endfunction

    function automatic logic model_done(input int s);
        logic d = 1'b0;
        for (int i = 0; i < n_tiles; i++)
            if (s - tile_t[i] == ROWS + WIDTH + 1) d = 1'b1;
        return d;
    endfunction

    task automatic new_tile_data(input int i, input bit pattern);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < WIDTH; c++)
                tile_dat[i][r][c] = pattern ? 8'(r * 16 + c) : 8'($urandom);
    endtask

    // Drives edges T..T+ncyc (T = first edge) and records outputs; no checking here.
    task automatic play(input int ncyc, input int extra_k, input logic [7:0] extra_base);
        for (int k = 0; k <= ncyc; k++) begin
            start     = 1'b0;
            base_addr = 8'($urandom);
            for (int i = 0; i < n_tiles; i++)
                if (tile_t[i] == k) begin
                    start     = 1'b1;
                    base_addr = tile_base[i];
                end
            if (k == extra_k) begin
                start     = 1'b1;
                base_addr = extra_base;
            end
            for (int c = 0; c < WIDTH; c++) begin
                logic [7:0] v = 8'($urandom);
                for (int i = 0; i < n_tiles; i++) begin
                    int r = k - tile_t[i] - 1 - c;
                    if (r >= 0 && r < ROWS) v = tile_dat[i][r][c];
                end
                col_in[c*DATA_W +: DATA_W] = v;
            end
            @(posedge clk);
            #1;
            obs_en[k+1]   = wr_en;
            obs_addr[k+1] = wr_addr;
            obs_data[k+1] = wr_data;
            obs_busy[k+1] = busy;
            obs_done[k+1] = done;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wr_en !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_wr en=%h addr=%h data=%h required all 0", wr_en, wr_addr, wr_data);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
        end
        reset = 1'b0;
        repeat (3) begin
            col_in = {4{32'($urandom)}};
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (wr_en !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release en=%h busy=%b required 0 0", wr_en, busy);
        end
    endtask

    task automatic test_full_tile;
        int nwr = 0;
        new_tile_data(0, 1'b1);
        n_tiles = 1; tile_t[0] = 0; tile_base[0] = 8'h20;
        play(40, -1, 8'h00);
        for (int s = 1; s <= 41; s++) begin
            n_checks++;
            if (obs_en[s] !== model_en(s) || obs_addr[s] !== model_addr(s) || obs_data[s] !== model_data(s)) begin
                n_fail++;
                $display("FAIL full_writes t=T+%0d en=%h/%h addr=%h/%h data=%h/%h", s,
                         obs_en[s], model_en(s), obs_addr[s], model_addr(s), obs_data[s], model_data(s));
            end
            n_checks++;
            if (obs_busy[s] !== model_busy(s) || obs_done[s] !== model_done(s)) begin
                n_fail++;
                $display("FAIL full_flags t=T+%0d busy=%b/%b done=%b/%b", s,
                         obs_busy[s], model_busy(s), obs_done[s], model_done(s));
            end
            nwr += $countones(obs_en[s]);
        end
        n_checks++;
        if (nwr != 256) begin n_fail++; $display("FAIL full_count writes=%0d required 256", nwr); end
        n_checks++;
        if (obs_en[2] !== 16'h0001) begin n_fail++; $display("FAIL en_T2 got %h required 0001", obs_en[2]); end
        n_checks++;
        if (obs_en[17] !== 16'hFFFF) begin n_fail++; $display("FAIL en_T17 got %h required ffff", obs_en[17]); end
        n_checks++;
        if (obs_en[18] !== 16'hFFFE) begin n_fail++; $display("FAIL en_T18 got %h required fffe", obs_en[18]); end
        n_checks++;
        if (obs_en[32] !== 16'h8000) begin n_fail++; $display("FAIL en_T32 got %h required 8000", obs_en[32]); end
        n_checks++;
        if (obs_done[33] !== 1'b1 || obs_done[32] !== 1'b0 || obs_done[34] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_T33 got %b%b%b required 010", obs_done[32], obs_done[33], obs_done[34]);
        end
    endtask

    task automatic test_addr_wrap;
        new_tile_data(0, 1'b0);
        n_tiles = 1; tile_t[0] = 0; tile_base[0] = 8'hF8;
        play(34, -1, 8'h00);
        for (int s = 1; s <= 35; s++) begin
            n_checks++;
            if (obs_en[s] !== model_en(s) || obs_addr[s] !== model_addr(s) || obs_data[s] !== model_data(s)) begin
                n_fail++;
                $display("FAIL wrap_writes t=T+%0d en=%h/%h addr=%h/%h data=%h/%h", s,
                         obs_en[s], model_en(s), obs_addr[s], model_addr(s), obs_data[s], model_data(s));
            end
        end
        n_checks++;
        if (obs_en[15][3] !== 1'b1 || obs_addr[15][3*ADDR_W +: ADDR_W] !== 8'h02) begin
            n_fail++;
            $display("FAIL wrap_lane3_row10 en=%b addr=%h required 1 02",
                     obs_en[15][3], obs_addr[15][3*ADDR_W +: ADDR_W]);
        end
    endtask

    task automatic test_start_busy;
        int ndone = 0;
        new_tile_data(0, 1'b0);
        n_tiles = 1; tile_t[0] = 0; tile_base[0] = 8'h20;
        play(40, 5, 8'h80);
        for (int s = 1; s <= 41; s++) begin
            n_checks++;
            if (obs_en[s] !== model_en(s) || obs_addr[s] !== model_addr(s) || obs_data[s] !== model_data(s)) begin
                n_fail++;
                $display("FAIL busy_start_writes t=T+%0d en=%h/%h addr=%h/%h data=%h/%h", s,
                         obs_en[s], model_en(s), obs_addr[s], model_addr(s), obs_data[s], model_data(s));
            end
            if (obs_done[s] === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL busy_start_done pulses=%0d required 1", ndone); end
    endtask

    task automatic test_back_to_back;
        new_tile_data(0, 1'b0);
        new_tile_data(1, 1'b0);
        n_tiles = 2;
        tile_t[0] = 0;  tile_base[0] = 8'($urandom);
        tile_t[1] = 33; tile_base[1] = 8'($urandom);
        play(70, -1, 8'h00);
        for (int s = 1; s <= 71; s++) begin
            n_checks++;
            if (obs_en[s] !== model_en(s) || obs_addr[s] !== model_addr(s) || obs_data[s] !== model_data(s)) begin
                n_fail++;
                $display("FAIL b2b_writes t=T+%0d en=%h/%h addr=%h/%h data=%h/%h", s,
                         obs_en[s], model_en(s), obs_addr[s], model_addr(s), obs_data[s], model_data(s));
            end
            n_checks++;
            if (obs_busy[s] !== model_busy(s) || obs_done[s] !== model_done(s)) begin
                n_fail++;
                $display("FAIL b2b_flags t=T+%0d busy=%b/%b done=%b/%b", s,
                         obs_busy[s], model_busy(s), obs_done[s], model_done(s));
            end
        end
        n_checks++;
        if (obs_en[34] !== 16'h0000 || obs_en[35] !== 16'h0001) begin
            n_fail++;
            $display("FAIL b2b_first_write en34=%h en35=%h required 0000 0001", obs_en[34], obs_en[35]);
        end
    endtask

    task automatic test_reset_mid;
        new_tile_data(0, 1'b0);
        n_tiles = 1; tile_t[0] = 0; tile_base[0] = 8'h40;
        play(9, -1, 8'h00);
        n_checks++;
        if (obs_en[10] !== model_en(10) || obs_busy[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset en=%h/%h busy=%b/1", obs_en[10], model_en(10), obs_busy[10]);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
            n_fail++;
            $display("FAIL mid_async_clear en=%h busy=%b done=%b addr=%h data=%h required all 0",
                     wr_en, busy, done, wr_addr, wr_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            col_in    = {4{32'($urandom)}};
            base_addr = 8'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_after_reset cyc=%0d en=%h busy=%b done=%b required 0", k, wr_en, busy, done);
            end
        end
        new_tile_data(0, 1'b0);
        tile_base[0] = 8'($urandom);
        play(34, -1, 8'h00);
        for (int s = 1; s <= 35; s++) begin
            n_checks++;
            if (obs_en[s] !== model_en(s) || obs_addr[s] !== model_addr(s) || obs_data[s] !== model_data(s)
                || obs_done[s] !== model_done(s)) begin
                n_fail++;
                $display("FAIL mid_fresh_tile t=T+%0d en=%h/%h addr=%h/%h data=%h/%h", s,
                         obs_en[s], model_en(s), obs_addr[s], model_addr(s), obs_data[s], model_data(s));
            end
        end
    endtask

    task automatic test_idle;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            col_in    = {4{32'($urandom)}};
            base_addr = 8'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (wr_en !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cyc=%0d en=%h busy=%b done=%b required 0", k, wr_en, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_addr_wrap();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_out_writer.md
# sys_out_writer

Writer at the output end of the systolic datapath, the counterpart of the staggered weight-load path. It accepts the diagonally skewed result stream leaving the bottom of the array: lane c, row r arrives c cycles after lane 0, row r. It de-skews that stream into per-lane write enables, addresses and data for the banked memory array (`memArr`). One `start` pulse drives one ROWS×WIDTH result tile.

## Interface
Parameters:
- `WIDTH`, 16, number of lanes (array columns / memory banks)
- `ROWS`, 16, results written per lane per tile
- `DATA_W`, 8, bits per lane result
- `ADDR_W`, 8, bits per lane address

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  tile start pulse; sampled only in IDLE
- `base_addr`  in  ADDR_W  row-0 address, captured with `start`
- `col_in`  in  WIDTH*DATA_W  skewed array outputs; lane c at bits [c*DATA_W +: DATA_W]
- `wr_en`  out  WIDTH  per-lane memory write enable
- `wr_addr`  out  WIDTH*ADDR_W  per-lane address, same lane packing
- `wr_data`  out  WIDTH*DATA_W  per-lane write data, same lane packing
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse after the last write

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: counts the sample window.
  - DONE: one cycle, then returns to IDLE.
- IDLE→RUN: `start`=1 at edge T. `base_addr` is latched and the sample counter `cnt` is cleared to 0.
- RUN: `cnt` increments every cycle. Width is clog2(ROWS+WIDTH).
- Sampling rule in RUN: lane c samples `col_in` lane c when c ≤ `cnt` ≤ c+ROWS-1. The sample is row r = `cnt`-c.
- RUN→DONE: when `cnt` = ROWS+WIDTH-2, i.e. the last sample of lane WIDTH-1.
- DONE: `done`=1 for one cycle, then IDLE.
- Write generation: a sample taken at cycle t produces, on the next cycle, `wr_en[c]`=1, `wr_addr` lane c = `base_addr`+r, and `wr_data` lane c = the sampled value.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Lanes outside their window drive `wr_en`=0; their `wr_addr` and `wr_data` lanes are 0.
- No saturation or truncation; data passes through bit-exact.
- `start` in RUN or DONE is ignored; it is not queued.
- `col_in` is don't-care outside the sampling windows.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, FSM=IDLE, `cnt`=0.
- `start` at edge T: `busy`=1 from T+1. Lane c row r is sampled at T+1+r+c and written at T+2+r+c.
- First write at T+2 (lane 0). The last write at T+ROWS+WIDTH occurs in the DONE cycle (lane WIDTH-1); `done` pulses the cycle after it, at T+ROWS+WIDTH+1, in IDLE.
- `busy` falls at T+ROWS+WIDTH+1. A new `start` may be accepted at that edge, so back-to-back tiles have one idle gap cycle.
- Reset asserted mid-tile: all outputs clear immediately (asynchronous). No writes occur after reset deasserts, and the tile is abandoned.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package (`tpu_pkg`) holds the FSM state enum `sow_state_t` {IDLE, RUN, DONE}. It also holds the lane-slice width constants shared with the weight-load control.
- One sub-module, `sys_out_lane`: per-lane window compare plus the `wr_en`, `wr_addr` and `wr_data` registers. It is instantiated WIDTH times with its lane index as a parameter.
- The top level holds the FSM, `cnt`, the `base_addr` latch, and `done`.

## Test plan
All scenarios use WIDTH=16, ROWS=16, DATA_W=8, ADDR_W=8.
- **Full tile:** `start` at T with `base_addr`=0x20; drive lane c at its slot r with r*16+c. Expect:
  - 256 writes, each to address 0x20+r with data r*16+c.
  - `wr_en` = 16'h0001 at T+2, 16'hFFFF at T+17, 16'hFFFE at T+18, 16'h8000 at T+32.
  - `done`=1 at T+33 only.
- **Address wrap:** `base_addr`=0xF8. Expect lane 3 row 10 written at address 0x02 at T+15.
- **Start while busy:** a second `start` at T+5 with `base_addr`=0x80. Expect no effect; all writes still use 0x20 and `done` pulses once.
- **Back-to-back tiles:** `start` at T and again at T+33 (the cycle `done`=1). Expect the second tile's first write at T+35.
- **Reset mid-tile:** assert `reset` at T+10. Expect:
  - `wr_en`, `busy` and `done` at 0 within the same cycle.
  - No writes after deassertion.
  - A fresh `start` then runs a normal tile.
- **Idle inputs:** `col_in` toggling with no `start`. Expect `wr_en`=0 and `busy`=0 throughout.
